// File: rtl/conv_sequencer.sv
// Instruction sequencer for the convolution core: one start pulse steps the core
// through every kernel position (weight fill, kernel load, activation fill, execute, psum write).
module conv_sequencer #(
  parameter int          COL     = 8,
  parameter int          ROW     = 8,
  parameter int          LEN_NIJ = 36,
  parameter int          NIJ_SZ  = 6,
  parameter int          LEN_KIJ = 9,
  parameter int          GAP_CYC = 10,
  parameter logic [10:0] W_BASE  = 11'h400
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  output logic [33:0] inst,
  output logic        mode,
  output logic        sel,
  output logic [3:0]  kij,
  output logic        busy,
  output logic        done
);

  localparam int CW = 16;
  localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] LAST_WL0  = CW'(COL - 1);
  localparam logic [CW-1:0] LAST_KLD  = CW'(ROW + COL - 1);
  localparam logic [CW-1:0] LAST_GAP  = CW'(GAP_CYC - 1);
  localparam logic [CW-1:0] LAST_NIJ  = CW'(LEN_NIJ - 1);
  localparam logic [CW-1:0] LAST_EXEC = CW'(LEN_NIJ + COL - 1);
  localparam logic [CW-1:0] COL_C     = CW'(COL);
  localparam logic [CW-1:0] NIJ_C     = CW'(LEN_NIJ);
  localparam logic [3:0]    KIJ_LAST  = 4'(LEN_KIJ - 1);
  localparam logic [10:0]   COL_A     = 11'(COL);
  localparam logic [10:0]   NIJ_SZ_A  = 11'(NIJ_SZ);
  localparam logic [33:0]   IDLE_INST = {1'b0, 1'b1, 1'b1, 11'd0, 1'b1, 1'b1, 11'd0, 7'd0};

  typedef enum logic [3:0] {
    S_IDLE, S_WL0, S_KLOAD, S_GAP, S_AL0, S_EXEC, S_OFRD, S_PWR, S_TAIL, S_DONE
  } state_t;

  state_t        state, state_seq, state_nxt;
  logic [CW-1:0] cnt, cnt_seq, cnt_nxt, last_cnt;
  logic [3:0]    kij_seq, kij_nxt;
  logic          at_end;

  logic          acc_n, cenp_n, wenp_n, cenx_n, wenx_n;
  logic [10:0]   ap_n, ax_n;
  logic          ofrd_n, l0rd_n, l0wr_n, ex_n, ld_n, done_n, busy_n;
  logic [33:0]   inst_n;

  // Final count value of the current state
  always_comb begin
    case (state)
      S_WL0:   last_cnt = LAST_WL0;
      S_KLOAD: last_cnt = LAST_KLD;
      S_GAP:   last_cnt = LAST_GAP;
      S_AL0:   last_cnt = LAST_NIJ;
      S_EXEC:  last_cnt = LAST_EXEC;
      S_PWR:   last_cnt = LAST_NIJ;
      S_TAIL:  last_cnt = CNT_ONE;
      default: last_cnt = CNT_ZERO;
    endcase
  end

  // Next state, state counter and kernel position; abort overrides everything
  always_comb begin
    state_seq = state;
    kij_seq   = kij;
    at_end    = (cnt == last_cnt);
    case (state)
      S_IDLE: begin
        kij_seq = 4'd0;
        if (start) state_seq = S_WL0;
        else       state_seq = S_IDLE;
      end
      S_WL0:   state_seq = at_end ? S_KLOAD : S_WL0;
      S_KLOAD: state_seq = at_end ? S_GAP   : S_KLOAD;
      S_GAP:   state_seq = at_end ? S_AL0   : S_GAP;
      S_AL0:   state_seq = at_end ? S_EXEC  : S_AL0;
      S_EXEC:  state_seq = at_end ? S_OFRD  : S_EXEC;
      S_OFRD:  state_seq = S_PWR;
      S_PWR:   state_seq = at_end ? S_TAIL  : S_PWR;
      S_TAIL: begin
        if (!at_end) begin
          state_seq = S_TAIL;
        end else if (kij == KIJ_LAST) begin
          state_seq = S_DONE;
        end else begin
          state_seq = S_WL0;
          kij_seq   = kij + 4'd1;
        end
      end
      S_DONE: begin
        state_seq = S_IDLE;
        kij_seq   = 4'd0;
      end
      default: begin
        state_seq = S_IDLE;
        kij_seq   = 4'd0;
      end
    endcase
    cnt_seq = (state_seq != state || state == S_IDLE) ? CNT_ZERO : cnt + CNT_ONE;

    state_nxt = abort ? S_IDLE   : state_seq;
    cnt_nxt   = abort ? CNT_ZERO : cnt_seq;
    kij_nxt   = abort ? 4'd0     : kij_seq;
  end

  // Output word for the upcoming cycle, decoded from the next state so outputs can be registered
  always_comb begin
    acc_n  = 1'b0;
    cenp_n = 1'b1;
    wenp_n = 1'b1;
    ap_n   = 11'd0;
    cenx_n = 1'b1;
    wenx_n = 1'b1;
    ax_n   = 11'd0;
    ofrd_n = 1'b0;
    l0rd_n = 1'b0;
    l0wr_n = 1'b0;
    ex_n   = 1'b0;
    ld_n   = 1'b0;
    done_n = 1'b0;
    case (state_nxt)
      S_WL0: begin
        cenx_n = 1'b0;
        l0wr_n = 1'b1;
        ax_n   = W_BASE + 11'(kij_nxt) * COL_A + 11'(cnt_nxt);
      end
      S_KLOAD: begin
        l0rd_n = 1'b1;
        ld_n   = (cnt_nxt < COL_C);
      end
      S_AL0: begin
        cenx_n = 1'b0;
        l0wr_n = 1'b1;
        ax_n   = 11'(cnt_nxt);
      end
      S_EXEC: begin
        l0rd_n = 1'b1;
        ex_n   = (cnt_nxt < NIJ_C);
      end
      S_OFRD: begin
        ofrd_n = 1'b1;
        acc_n  = (kij_nxt != 4'd0);
      end
      // Output pixel index shifted back by the kernel offset; wraps negative for early pixels
      S_PWR: begin
        ofrd_n = 1'b1;
        cenp_n = 1'b0;
        wenp_n = 1'b0;
        acc_n  = (kij_nxt != 4'd0);
        ap_n   = 11'(cnt_nxt) - 11'(kij_nxt % 4'd3) - 11'(kij_nxt / 4'd3) * NIJ_SZ_A;
      end
      S_TAIL:  acc_n  = (kij_nxt != 4'd0) && (cnt_nxt == CNT_ZERO);
      S_DONE:  done_n = 1'b1;
      default: done_n = 1'b0;
    endcase
    inst_n = {acc_n, cenp_n, wenp_n, ap_n, cenx_n, wenx_n, ax_n,
              ofrd_n, 1'b0, 1'b0, l0rd_n, l0wr_n, ex_n, ld_n};
    busy_n = (state_nxt != S_IDLE);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      cnt   <= CNT_ZERO;
      kij   <= 4'd0;
      inst  <= IDLE_INST;
      mode  <= 1'b0;
      sel   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      kij   <= kij_nxt;
      inst  <= inst_n;
      mode  <= busy_n;
      sel   <= busy_n & kij_nxt[0];
      busy  <= busy_n;
      done  <= done_n;
    end
  end

endmodule

// File: tb/tb_conv_sequencer.sv
// Directed bench for conv_sequencer: timed vector table over a full run plus
// reset, abort and start/abort corner sequences.
module tb_conv_sequencer;

  logic        clk = 1'b0;
  logic        reset, start, abort;
  logic [33:0] inst;
  logic        mode, sel, busy, done;
  logic [3:0]  kij;

  conv_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .inst(inst), .mode(mode), .sel(sel), .kij(kij), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          t;
    logic [33:0] inst;
    logic        sel;
    logic [3:0]  kij;
    logic        busy;
    logic        done;
  } vec_t;

  vec_t        vecs[$];
  int          nvec = 0;
  int          nerr = 0;
  int          ld_c[9], wr_c[9], ex_c[9], pw_c[9], ac_c[9];
  int          busy_c, done_c, idx, td;
  logic [33:0] idle_w;

  // acc, pmem write, A_pmem, xmem read, A_xmem, ofifo_rd, l0_rd, l0_wr, execute, load
  function automatic logic [33:0] w(logic acc, logic pmw, logic [10:0] ap, logic xrd,
                                    logic [10:0] ax, logic ofrd, logic l0rd, logic l0wr,
                                    logic ex, logic ld);
    return {acc, ~pmw, ~pmw, ap, ~xrd, 1'b1, ax, ofrd, 1'b0, 1'b0, l0rd, l0wr, ex, ld};
  endfunction

  task automatic add(int t, logic [33:0] i, logic s, logic [3:0] k, logic b, logic d);
    vec_t v;
    v.t = t; v.inst = i; v.sel = s; v.kij = k; v.busy = b; v.done = d;
    vecs.push_back(v);
  endtask

  task automatic chk(string nm, logic [33:0] ei, logic es, logic [3:0] ek, logic eb, logic ed);
    nvec++;
    if (inst !== ei || mode !== eb || sel !== es || kij !== ek || busy !== eb || done !== ed) begin
      nerr++;
      $display("FAIL %s: got inst=%h mode=%b sel=%b kij=%0d busy=%b done=%b, want inst=%h mode=%b sel=%b kij=%0d busy=%b done=%b",
               nm, inst, mode, sel, kij, busy, done, ei, eb, es, ek, eb, ed);
    end
  endtask

  task automatic chk_int(string nm, int got, int want);
    nvec++;
    if (got != want) begin
      nerr++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  task automatic go();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  initial begin
    idle_w = w(1'b0, 1'b0, 11'd0, 1'b0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    add(0,    w(0,0,11'h000,1,11'h400,0,0,1,0,0), 1'b0, 4'd0, 1'b1, 1'b0);
    add(7,    w(0,0,11'h000,1,11'h407,0,0,1,0,0), 1'b0, 4'd0, 1'b1, 1'b0);
    add(8,    w(0,0,11'h000,0,11'h000,0,1,0,0,1), 1'b0, 4'd0, 1'b1, 1'b0);
    add(16,   w(0,0,11'h000,0,11'h000,0,1,0,0,0), 1'b0, 4'd0, 1'b1, 1'b0);
    add(24,   idle_w,                             1'b0, 4'd0, 1'b1, 1'b0);
    add(34,   w(0,0,11'h000,1,11'h000,0,0,1,0,0), 1'b0, 4'd0, 1'b1, 1'b0);
    add(69,   w(0,0,11'h000,1,11'h023,0,0,1,0,0), 1'b0, 4'd0, 1'b1, 1'b0);
    add(70,   w(0,0,11'h000,0,11'h000,0,1,0,1,0), 1'b0, 4'd0, 1'b1, 1'b0);
    add(106,  w(0,0,11'h000,0,11'h000,0,1,0,0,0), 1'b0, 4'd0, 1'b1, 1'b0);
    add(114,  w(0,0,11'h000,0,11'h000,1,0,0,0,0), 1'b0, 4'd0, 1'b1, 1'b0);
    add(115,  w(0,1,11'h000,0,11'h000,1,0,0,0,0), 1'b0, 4'd0, 1'b1, 1'b0);
    add(150,  w(0,1,11'h023,0,11'h000,1,0,0,0,0), 1'b0, 4'd0, 1'b1, 1'b0);
    add(151,  idle_w,                             1'b0, 4'd0, 1'b1, 1'b0);
    add(153,  w(0,0,11'h000,1,11'h408,0,0,1,0,0), 1'b1, 4'd1, 1'b1, 1'b0);
    add(267,  w(1,0,11'h000,0,11'h000,1,0,0,0,0), 1'b1, 4'd1, 1'b1, 1'b0);
    add(612,  w(0,0,11'h000,1,11'h420,0,0,1,0,0), 1'b0, 4'd4, 1'b1, 1'b0);
    add(619,  w(0,0,11'h000,1,11'h427,0,0,1,0,0), 1'b0, 4'd4, 1'b1, 1'b0);
    add(726,  w(1,0,11'h000,0,11'h000,1,0,0,0,0), 1'b0, 4'd4, 1'b1, 1'b0);
    add(727,  w(1,1,11'h7F9,0,11'h000,1,0,0,0,0), 1'b0, 4'd4, 1'b1, 1'b0);
    add(763,  w(1,0,11'h000,0,11'h000,0,0,0,0,0), 1'b0, 4'd4, 1'b1, 1'b0);
    add(764,  idle_w,                             1'b0, 4'd4, 1'b1, 1'b0);
    add(1339, w(1,1,11'h7F2,0,11'h000,1,0,0,0,0), 1'b0, 4'd8, 1'b1, 1'b0);
    add(1353, w(1,1,11'h000,0,11'h000,1,0,0,0,0), 1'b0, 4'd8, 1'b1, 1'b0);
    add(1376, idle_w,                             1'b0, 4'd8, 1'b1, 1'b0);
    add(1377, idle_w,                             1'b0, 4'd8, 1'b1, 1'b1);
    add(1378, idle_w,                             1'b0, 4'd0, 1'b0, 1'b0);

    reset = 1'b0; start = 1'b0; abort = 1'b0;
    @(negedge clk);
    chk("reset_state", idle_w, 1'b0, 4'd0, 1'b0, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    chk("idle_no_start", idle_w, 1'b0, 4'd0, 1'b0, 1'b0);

    // Full run, with a start pulse during KLOAD that must be ignored
    for (int k = 0; k < 9; k++) begin
      ld_c[k] = 0; wr_c[k] = 0; ex_c[k] = 0; pw_c[k] = 0; ac_c[k] = 0;
    end
    busy_c = 0; done_c = 0; idx = 0;
    go();
    for (int t = 0; t <= 1378; t++) begin
      start = (t == 10);
      if (t < 1377) begin
        if (inst[0])                ld_c[t/153]++;
        if (inst[2])                wr_c[t/153]++;
        if (inst[1])                ex_c[t/153]++;
        if (!inst[32] && !inst[31]) pw_c[t/153]++;
        if (inst[33])               ac_c[t/153]++;
      end
      if (busy && !done) busy_c++;
      if (done)          done_c++;
      while (idx < vecs.size() && vecs[idx].t == t) begin
        chk($sformatf("run_t%0d", t), vecs[idx].inst, vecs[idx].sel, vecs[idx].kij,
            vecs[idx].busy, vecs[idx].done);
        idx++;
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk_int("busy_cycles", busy_c, 1377);
    chk_int("done_cycles", done_c, 1);
    for (int k = 0; k < 9; k++) begin
      chk_int($sformatf("load_k%0d", k), ld_c[k], 8);
      chk_int($sformatf("l0wr_k%0d", k), wr_c[k], 44);
      chk_int($sformatf("exec_k%0d", k), ex_c[k], 36);
      chk_int($sformatf("pwr_k%0d", k),  pw_c[k], 36);
      chk_int($sformatf("acc_k%0d", k),  ac_c[k], (k == 0) ? 0 : 38);
    end

    // Asynchronous reset during EXEC of kij=3, then a full restart
    go();
    repeat (539) @(negedge clk);
    chk("exec_k3", w(0,0,11'h000,0,11'h000,0,1,0,1,0), 1'b1, 4'd3, 1'b1, 1'b0);
    reset = 1'b0;
    #1;
    chk("async_reset", idle_w, 1'b0, 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk("reset_held", idle_w, 1'b0, 4'd0, 1'b0, 1'b0);
    reset = 1'b1;
    go();
    chk("restart_first", w(0,0,11'h000,1,11'h400,0,0,1,0,0), 1'b0, 4'd0, 1'b1, 1'b0);
    td = -1;
    for (int t = 0; t < 2000 && td < 0; t++) begin
      if (done) td = t;
      else @(negedge clk);
    end
    chk_int("restart_done_cycle", td, 1377);
    @(negedge clk);

    // Abort during PWR of kij=2
    go();
    repeat (426) @(negedge clk);
    chk("pwr_k2", w(1,1,11'h003,0,11'h000,1,0,0,0,0), 1'b0, 4'd2, 1'b1, 1'b0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_idle", idle_w, 1'b0, 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk("abort_stays", idle_w, 1'b0, 4'd0, 1'b0, 1'b0);
    go();
    chk("abort_restart", w(0,0,11'h000,1,11'h400,0,0,1,0,0), 1'b0, 4'd0, 1'b1, 1'b0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_again", idle_w, 1'b0, 4'd0, 1'b0, 1'b0);

    // start and abort together in IDLE
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("start_abort", idle_w, 1'b0, 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk("start_abort_hold", idle_w, 1'b0, 4'd0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/conv_sequencer.md
# conv_sequencer

Hardware instruction sequencer for the convolution core. It replaces host-driven stepping with a single `start` pulse, then drives the core's 34-bit `inst` word, `mode` and `sel` through all `LEN_KIJ` kernel positions. For each kernel position it issues the weight L0 fill, the PE kernel load, a drain gap, the activation L0 fill, execution, and the OFIFO-to-pmem write with accumulation. It sits between the top-level control and `core`.

## Interface
Parameters:
- `COL`, 8: PE array columns; equals the weight rows per kij.
- `ROW`, 8: PE array rows.
- `LEN_NIJ`, 36: input activation vectors.
- `NIJ_SZ`, 6: input feature-map width.
- `LEN_KIJ`, 9: kernel positions; kernel is 3x3.
- `GAP_CYC`, 10: idle cycles after kernel load.
- `W_BASE`, 11'h400: xmem address of kij0 weights. kij k weights occupy `W_BASE + k*COL` onward.

Ports:
- `clk`, in, 1: clock; all logic on the rising edge.
- `reset`, in, 1: asynchronous, active-low.
- `start`, in, 1: one-cycle request; honoured only in IDLE.
- `abort`, in, 1: synchronous; forces IDLE on the next edge.
- `inst`, out, 34: core instruction. Bit 33 acc, 32 CEN_pmem, 31 WEN_pmem, 30:20 A_pmem, 19 CEN_xmem, 18 WEN_xmem, 17:7 A_xmem, 6 ofifo_rd, 5 ififo_wr, 4 ififo_rd, 3 l0_rd, 2 l0_wr, 1 execute, 0 load.
- `mode`, out, 1: core mode; 1 whenever busy.
- `sel`, out, 1: pmem bank select, equal to kij[0].
- `kij`, out, 4: current kernel position.
- `busy`, out, 1: high from the first non-IDLE cycle through DONE.
- `done`, out, 1: one-cycle pulse at run end.

## Operation
- All outputs are registered.
- Idle word: `inst` = CEN_pmem=1, WEN_pmem=1, CEN_xmem=1, WEN_xmem=1, all other bits 0. `mode`=0, `sel`=0, `kij`=0, `busy`=0, `done`=0.
- A state counter `cnt` clears on every state entry.
- States and per-cycle outputs. Each state drives its listed fields; all other fields take idle values.
  - IDLE: on `start`, go to WL0 with kij=0.
  - WL0, `COL` cycles: CEN_xmem=0, l0_wr=1, A_xmem=`W_BASE + kij*COL + cnt`.
  - KLOAD, `ROW+COL` cycles: l0_rd=1; load=1 while cnt<`COL`.
  - GAP, `GAP_CYC` cycles: idle word with mode=1.
  - AL0, `LEN_NIJ` cycles: CEN_xmem=0, l0_wr=1, A_xmem=cnt.
  - EXEC, `LEN_NIJ+COL` cycles: l0_rd=1; execute=1 while cnt<`LEN_NIJ`.
  - OFRD, 1 cycle: ofifo_rd=1; acc=(kij!=0).
  - PWR, `LEN_NIJ` cycles: ofifo_rd=1, CEN_pmem=0, WEN_pmem=0, acc=(kij!=0).
    - A_pmem = `(cnt - (kij%3) - (kij/3)*NIJ_SZ)` mod 2^11. The subtraction wraps modulo 2^11 with no saturation.
  - TAIL, 2 cycles: acc=(kij!=0) in cnt=0, 0 in cnt=1.
    - At the end, if kij=`LEN_KIJ`-1, go to DONE; otherwise increment kij and go to WL0.
  - DONE, 1 cycle: done=1, busy=1. Then IDLE.
- `sel` tracks kij[0] in every non-IDLE state.
- Cycle count per kij: COL + (ROW+COL) + GAP_CYC + LEN_NIJ + (LEN_NIJ+COL) + 1 + LEN_NIJ + 2. With defaults this is 153; a full run is 1377 cycles plus DONE.

## Timing
- Start latency: `start` sampled high in IDLE at edge N. The first WL0 word appears after edge N, and `busy` rises at the same time.
- Boundary conditions:
  - `start` while busy: ignored; no restart, no queueing.
  - `start` and `abort` together in IDLE: abort wins; the block stays IDLE.
  - `abort` in any state: the next edge gives the idle word, kij=0, busy=0, done=0. No partial pmem write continues.
  - `reset` low at any time: immediately forces all outputs to idle values and the state to IDLE, asynchronously. Deassertion takes effect at the next edge.
  - kij wrap: kij never exceeds `LEN_KIJ`-1; it returns to 0 in IDLE.
  - A_pmem for kij>0 starts negative (wrapped). kij=8 start value is 11'h7F2; it reaches nonnegative values after 14 cycles.

## Test plan
- Reset: hold `reset`=0 mid-run (during EXEC of kij=3) -> outputs go to the idle word immediately; busy=0, kij=0; a new `start` afterwards runs a full sequence from kij=0.
- Full run: single `start` -> exactly 1377 busy cycles before DONE, `done` high for one cycle. Per-field counts per kij: load=8, l0_wr=44, execute=36, pmem writes=36.
- Addresses:
  - kij=0: WL0 A_xmem 0x400..0x407; PWR A_pmem 0x000..0x023.
  - kij=4: WL0 A_xmem 0x420..0x427; first PWR A_pmem=11'h7F9.
- Accumulation and select: acc=0 throughout kij=0. For kij≥1, acc=1 for OFRD, PWR and TAIL cnt=0 (38 cycles). `sel` alternates 0,1,0,… per kij.
- Abort: `abort` in PWR of kij=2 -> idle word on the next cycle; a subsequent `start` restarts at kij=0.
- Ignored start: pulse `start` during KLOAD -> sequence and total cycle count unchanged.
